// File: rtl/fix_msg_capture_pkg.sv
// fix_pkg: shared state encoding and default geometry for the FIX message capture buffer.
package fix_pkg;
    localparam int FIX_ADDR_WIDTH = 8;
    localparam int FIX_DATA_WIDTH = 8;
    typedef enum logic [2:0] {IDLE, CAP_I, CAP_A, READY, DRAIN} cap_state_t;
endpackage

// File: rtl/fix_msg_capture_ram.sv
// fix_msg_capture_ram: single-port synchronous RAM, write-enable plus registered read.
module fix_msg_capture_ram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end
endmodule

// File: rtl/fix_msg_capture.sv
// fix_msg_capture: captures one FIX message from initiator or acceptor engine into a RAM buffer,
// exposes length/checksum/source, then drains it byte by byte.
module fix_msg_capture
    import fix_pkg::*;
#(
    parameter int ADDR_WIDTH = FIX_ADDR_WIDTH,
    parameter int DATA_WIDTH = FIX_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  end_i,
    input  logic                  wr_a,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic                  end_a,
    output logic                  full_i,
    output logic                  full_a,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_last,
    input  logic                  msg_clear,
    output logic                  msg_ready,
    output logic [ADDR_WIDTH:0]   msg_len,
    output logic [DATA_WIDTH-1:0] msg_sum,
    output logic                  msg_src,
    output logic                  overflow
);
    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    cap_state_t state, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr, addr;
    logic [DATA_WIDTH-1:0] wdata, ram_q;
    logic idle, cap_i, cap_a, hold, full_len, acc, drop, rd_go, last_rd;

    assign idle     = state == IDLE;
    assign cap_i    = state == CAP_I;
    assign cap_a    = state == CAP_A;
    assign hold     = state == READY || state == DRAIN;
    assign full_len = msg_len == DEPTH;
    assign full_i   = cap_a || hold || (cap_i && full_len);
    assign full_a   = cap_i || hold || (cap_a && full_len);
    assign acc      = idle ? (wr_i || wr_a) : cap_i ? (wr_i && !full_len) : cap_a && wr_a && !full_len;
    // In IDLE neither source is full; the only drop there is the losing acceptor in a collision.
    assign drop     = (wr_i && full_i) || (wr_a && full_a) || (idle && wr_i && wr_a);
    assign wdata    = (idle ? wr_i : cap_i) ? data_i : data_a;
    assign rd_go    = hold && rd_en;
    assign last_rd  = rd_go && ({1'b0, rd_ptr} == msg_len - (ADDR_WIDTH+1)'(1));
    assign addr     = hold ? rd_ptr : wr_ptr;
    assign msg_ready = hold;
    assign rd_data  = rd_valid ? ram_q : '0;

    fix_msg_capture_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_ram (
        .clk(clk), .we(acc), .addr(addr), .wdata(wdata), .rdata(ram_q)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:         state_d = wr_i ? (end_i ? READY : CAP_I) : wr_a ? (end_a ? READY : CAP_A) : IDLE;
            CAP_I:        state_d = (end_i && (msg_len != '0 || wr_i)) ? READY : CAP_I;
            CAP_A:        state_d = (end_a && (msg_len != '0 || wr_a)) ? READY : CAP_A;
            READY, DRAIN: state_d = last_rd ? IDLE : rd_go ? DRAIN : state;
            default:      state_d = IDLE;
        endcase
        if (msg_clear) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            msg_len  <= '0;
            msg_sum  <= '0;
            msg_src  <= 1'b0;
            overflow <= 1'b0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
        end else if (msg_clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            msg_len  <= '0;
            msg_sum  <= '0;
            msg_src  <= 1'b0;
            overflow <= 1'b0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
        end else begin
            rd_valid <= rd_go;
            rd_last  <= last_rd;
            if (drop) overflow <= 1'b1;
            if (acc) begin
                wr_ptr  <= wr_ptr + ADDR_WIDTH'(1);
                msg_len <= msg_len + (ADDR_WIDTH+1)'(1);
                msg_sum <= msg_sum + wdata;
                if (idle) msg_src <= !wr_i;
            end
            if (rd_go) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            // Final byte issued: the buffer is released while its data is still in flight from the RAM.
            if (last_rd) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                msg_len <= '0;
                msg_sum <= '0;
            end
        end
    end
endmodule

// File: tb/tb_fix_msg_capture.sv
// tb_fix_msg_capture: scoreboard bench; written bytes are queued and compared as the DUT drains them.
module tb_fix_msg_capture;
    logic clk = 1'b0, reset = 1'b0;
    logic wr_i = 0, end_i = 0, wr_a = 0, end_a = 0, rd_en = 0, msg_clear = 0;
    logic [7:0] data_i = 0, data_a = 0;
    logic full_i, full_a, rd_valid, rd_last, msg_ready, msg_src, overflow;
    logic [7:0] rd_data, msg_sum;
    logic [8:0] msg_len;

    int vectors = 0, miscompares = 0, pops = 0;
    logic [7:0] q[$];
    logic [8:0] exp_len = 0;
    logic [7:0] exp_sum = 0;
    logic [7:0] fix_msg [5] = '{8'h38, 8'h3D, 8'h46, 8'h49, 8'h58};

    fix_msg_capture dut (
        .clk(clk), .reset(reset),
        .wr_i(wr_i), .data_i(data_i), .end_i(end_i),
        .wr_a(wr_a), .data_a(data_a), .end_a(end_a),
        .full_i(full_i), .full_a(full_a),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
        .msg_clear(msg_clear), .msg_ready(msg_ready), .msg_len(msg_len),
        .msg_sum(msg_sum), .msg_src(msg_src), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        logic [7:0] e;
        if (reset && rd_valid) begin
            pops++;
            check("rd_q_nonempty", q.size() != 0, 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("rd_data", rd_data, e);
                check("rd_last", rd_last, q.size() == 0);
            end
        end
    end

    task automatic push(input bit src, input logic [7:0] d, input bit e, input bit keep);
        wr_i = !src; wr_a = src; data_i = d; data_a = d; end_i = e && !src; end_a = e && src;
        if (keep) begin
            q.push_back(d);
            exp_len++;
            exp_sum += d;
        end
        @(negedge clk);
        wr_i = 0; wr_a = 0; end_i = 0; end_a = 0;
    endtask

    task automatic check_msg(input bit src);
        check("msg_ready", msg_ready, 1);
        check("msg_len", msg_len, exp_len);
        check("msg_sum", msg_sum, exp_sum);
        check("msg_src", msg_src, src);
        check("full_i_held", full_i, 1);
        check("full_a_held", full_a, 1);
    endtask

    task automatic drain(input int n);
        pops = 0;
        rd_en = 1;
        repeat (n) @(negedge clk);
        rd_en = 0;
        @(negedge clk);
        check("pops", pops, n);
        check("rd_valid_off", rd_valid, 0);
        check("ready_after", msg_ready, 0);
        check("len_after", msg_len, 0);
        check("sum_after", msg_sum, 0);
        check("q_empty", q.size(), 0);
        exp_len = 0;
        exp_sum = 0;
    endtask

    task automatic clear();
        msg_clear = 1;
        @(negedge clk);
        msg_clear = 0;
        q.delete();
        exp_len = 0;
        exp_sum = 0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rd_valid"}, rd_valid, 0);
        check({tag, "_rd_data"}, rd_data, 0);
        check({tag, "_rd_last"}, rd_last, 0);
        check({tag, "_ready"}, msg_ready, 0);
        check({tag, "_len"}, msg_len, 0);
        check({tag, "_sum"}, msg_sum, 0);
        check({tag, "_src"}, msg_src, 0);
        check({tag, "_ovf"}, overflow, 0);
        check({tag, "_full_i"}, full_i, 0);
        check({tag, "_full_a"}, full_a, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_zero("rst");
        reset = 1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) push(0, fix_msg[i], i == 4, 1);
        check_msg(0);
        drain(5);

        wr_i = 1; wr_a = 1; data_i = 8'h41; data_a = 8'h42;
        q.push_back(8'h41); exp_len = 1; exp_sum = 8'h41;
        @(negedge clk);
        wr_i = 0; wr_a = 0;
        check("coll_full_a", full_a, 1);
        check("coll_full_i", full_i, 0);
        check("coll_ovf", overflow, 1);
        check("coll_len", msg_len, 1);
        end_i = 1;
        @(negedge clk);
        end_i = 0;
        check_msg(0);
        drain(1);
        check("ovf_sticky", overflow, 1);
        clear();
        check("ovf_cleared", overflow, 0);

        for (int i = 0; i < 7; i++) push(0, 8'($urandom), i == 6, 1);
        check_msg(0);
        drain(7);

        for (int i = 0; i < 257; i++) begin
            push(1, 8'h01, i == 256, i < 256);
            if (i == 255) begin
                check("sat_full_a", full_a, 1);
                check("sat_full_i", full_i, 1);
                check("sat_len", msg_len, 256);
                check("sat_ovf_pre", overflow, 0);
            end
        end
        check_msg(1);
        check("sat_ovf", overflow, 1);
        drain(256);
        clear();

        rd_en = 1;
        @(negedge clk);
        rd_en = 0;
        @(negedge clk);
        check("idle_rd_ignored", rd_valid, 0);
        for (int i = 0; i < 3; i++) push(1, 8'hC0 + 8'(i), i == 2, 1);
        check_msg(1);
        drain(3);

        for (int i = 0; i < 4; i++) push(1, 8'h10 + 8'(i), 0, 1);
        check("capa_full_i", full_i, 1);
        check("capa_len", msg_len, 4);
        clear();
        check("clr_len", msg_len, 0);
        check("clr_full_i", full_i, 0);
        check("clr_ready", msg_ready, 0);
        push(0, 8'hAA, 0, 1);
        push(0, 8'hBB, 1, 1);
        check_msg(0);
        drain(2);

        for (int i = 0; i < 4; i++) push(1, 8'h60 + 8'(i), i == 3, 1);
        wr_i = 1;
        @(negedge clk);
        wr_i = 0;
        check("pre_rst_ovf", overflow, 1);
        check("pre_rst_src", msg_src, 1);
        rd_en = 1;
        repeat (2) @(negedge clk);
        #2 reset = 0;
        #1 check_zero("async_rst");
        rd_en = 0;
        q.delete();
        exp_len = 0;
        exp_sum = 0;
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        push(0, 8'h77, 1, 1);
        check_msg(0);
        drain(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
